// File: rtl/calc3_dispatch_sched_if.sv
// calc3_dispatch_sched_if: port command/response and engine dispatch bundle for the Calc3 scheduler.
// Defining CALC3_SCHED_PERF_EN adds the per-port grant counters.
interface calc3_dispatch_sched_if;
  logic [3:0][3:0]  cmd_in, d1_in, d2_in, r1_in;
  logic [3:0][31:0] data_in;
  logic [3:0][1:0]  tag_in;
  logic [3:0]       port_rdy;
  logic             exe_valid, exe_ready;
  logic [3:0]       exe_cmd, exe_d1, exe_d2, exe_r1;
  logic [31:0]      exe_data;
  logic [1:0]       exe_port, exe_tag;
  logic             exe_rsp_valid;
  logic [1:0]       exe_rsp_port, exe_rsp_tag, exe_rsp_resp;
  logic [31:0]      exe_rsp_data;
  logic [3:0][1:0]  resp_out, tag_out;
  logic [3:0][31:0] data_out;
`ifdef CALC3_SCHED_PERF_EN
  logic [3:0][15:0] perf_grant_cnt;
  modport master (output cmd_in, d1_in, d2_in, r1_in, data_in, tag_in, exe_ready, exe_rsp_valid,
                  exe_rsp_port, exe_rsp_tag, exe_rsp_resp, exe_rsp_data,
                  input port_rdy, exe_valid, exe_cmd, exe_d1, exe_d2, exe_r1, exe_data, exe_port,
                  exe_tag, resp_out, tag_out, data_out, perf_grant_cnt);
  modport slave (input cmd_in, d1_in, d2_in, r1_in, data_in, tag_in, exe_ready, exe_rsp_valid,
                 exe_rsp_port, exe_rsp_tag, exe_rsp_resp, exe_rsp_data,
                 output port_rdy, exe_valid, exe_cmd, exe_d1, exe_d2, exe_r1, exe_data, exe_port,
                 exe_tag, resp_out, tag_out, data_out, perf_grant_cnt);
`else
  modport master (output cmd_in, d1_in, d2_in, r1_in, data_in, tag_in, exe_ready, exe_rsp_valid,
                  exe_rsp_port, exe_rsp_tag, exe_rsp_resp, exe_rsp_data,
                  input port_rdy, exe_valid, exe_cmd, exe_d1, exe_d2, exe_r1, exe_data, exe_port,
                  exe_tag, resp_out, tag_out, data_out);
  modport slave (input cmd_in, d1_in, d2_in, r1_in, data_in, tag_in, exe_ready, exe_rsp_valid,
                 exe_rsp_port, exe_rsp_tag, exe_rsp_resp, exe_rsp_data,
                 output port_rdy, exe_valid, exe_cmd, exe_d1, exe_d2, exe_r1, exe_data, exe_port,
                 exe_tag, resp_out, tag_out, data_out);
`endif
endinterface

// File: rtl/calc3_dispatch_sched.sv
// calc3_dispatch_sched: per-port command FIFOs, round-robin dispatch to one engine, tag scoreboards and response routing.
// Optional CALC3_SCHED_PERF_EN adds saturating per-port grant counters.
module calc3_dispatch_sched #(
  parameter int QDEPTH = 2,
  parameter int NPORT  = 4
) (
  input logic c_clk,
  input logic rst,
  calc3_dispatch_sched_if.slave bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int EW = 50;
  logic [EW-1:0]    mem_q [NPORT][QDEPTH];
  logic [AW-1:0]    wp_q [NPORT];
  logic [AW-1:0]    rp_q [NPORT];
  logic [AW:0]      cnt_q [NPORT];
  logic [3:0][3:0]  busy_q, busy_d, busy_eff;
  logic [3:0]       rej_q, rej_d, full, empty, rdy, push, pop, acc, rsp_to;
  logic [3:0][1:0]  rej_tag_q, rej_tag_d, resp_q, resp_d, tag_q, tag_d;
  logic [3:0][31:0] data_q, data_d;
  logic [1:0]       rr_q, win, exe_port_q;
  logic             found, load, rsp_hit, exe_valid_q;
  logic [EW-1:0]    exe_q, head;
  assign head = mem_q[win][rp_q[win]];
  always_comb begin
    load = !exe_valid_q || bus.exe_ready;
    rsp_hit = bus.exe_rsp_valid && busy_q[bus.exe_rsp_port][bus.exe_rsp_tag];
    for (int i = 0; i < NPORT; i++) begin
      full[i] = cnt_q[i] == (AW+1)'(QDEPTH);
      empty[i] = cnt_q[i] == '0;
      rdy[i] = !full[i] && !rej_q[i];
      rsp_to[i] = rsp_hit && bus.exe_rsp_port == 2'(i);
      for (int t = 0; t < 4; t++)
        busy_eff[i][t] = busy_q[i][t] && !(rsp_to[i] && bus.exe_rsp_tag == 2'(t));
      acc[i] = bus.cmd_in[i] != 4'd0 && rdy[i];
      // a tag returned by the engine at this edge may be reissued at the same edge
      push[i] = acc[i] && !busy_eff[i][bus.tag_in[i]] &&
                (bus.cmd_in[i] inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 4'd10, 4'd12, 4'd13});
      busy_d[i] = busy_eff[i] | (push[i] ? 4'd1 << bus.tag_in[i] : 4'd0);
      rej_d[i] = (rej_q[i] && rsp_to[i]) || (acc[i] && !push[i]);
      rej_tag_d[i] = acc[i] && !push[i] ? bus.tag_in[i] : rej_tag_q[i];
      resp_d[i] = rsp_to[i] ? bus.exe_rsp_resp : rej_q[i] ? 2'd2 : 2'd0;
      tag_d[i] = rsp_to[i] ? bus.exe_rsp_tag : rej_q[i] ? rej_tag_q[i] : 2'd0;
      data_d[i] = rsp_to[i] ? bus.exe_rsp_data : 32'd0;
    end
    found = 1'b0;
    win = rr_q;
    for (int k = NPORT; k >= 1; k--)
      if (!empty[2'(rr_q + 2'(k))]) begin
        found = 1'b1;
        win = 2'(rr_q + 2'(k));
      end
    for (int i = 0; i < NPORT; i++)
      pop[i] = load && found && win == 2'(i);
  end
  always_ff @(posedge c_clk)
    for (int i = 0; i < NPORT; i++)
      if (push[i])
        mem_q[i][wp_q[i]] <= {bus.cmd_in[i], bus.d1_in[i], bus.d2_in[i], bus.r1_in[i],
                              bus.data_in[i], bus.tag_in[i]};
  always_ff @(posedge c_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPORT; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      busy_q <= '0;
      rej_q <= '0;
      rej_tag_q <= '0;
      rr_q <= 2'd3;
      exe_valid_q <= 1'b0;
      exe_q <= '0;
      exe_port_q <= '0;
      resp_q <= '0;
      tag_q <= '0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        wp_q[i] <= wp_q[i] + AW'(push[i]);
        rp_q[i] <= rp_q[i] + AW'(pop[i]);
        cnt_q[i] <= cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
      busy_q <= busy_d;
      rej_q <= rej_d;
      rej_tag_q <= rej_tag_d;
      resp_q <= resp_d;
      tag_q <= tag_d;
      data_q <= data_d;
      if (load) exe_valid_q <= found;
      if (load && found) begin
        exe_q <= head;
        exe_port_q <= win;
        rr_q <= win;
      end
    end
  end
  assign bus.port_rdy = rdy;
  assign bus.exe_valid = exe_valid_q;
  assign {bus.exe_cmd, bus.exe_d1, bus.exe_d2, bus.exe_r1, bus.exe_data, bus.exe_tag} = exe_q;
  assign bus.exe_port = exe_port_q;
  assign bus.resp_out = resp_q;
  assign bus.tag_out = tag_q;
  assign bus.data_out = data_q;
`ifdef CALC3_SCHED_PERF_EN
  logic [3:0][15:0] perf_q;
  always_ff @(posedge c_clk or negedge rst) begin
    if (!rst) perf_q <= '0;
    else
      for (int i = 0; i < NPORT; i++)
        if (exe_valid_q && bus.exe_ready && exe_port_q == 2'(i) && perf_q[i] != 16'hFFFF)
          perf_q[i] <= perf_q[i] + 16'd1;
  end
  assign bus.perf_grant_cnt = perf_q;
`endif
endmodule
